// File: rtl/program_loader_if.sv
// Byte-stream in / program-memory write out bundle for the program loader.
// The loader takes the slave view; whatever feeds bytes and watches writes takes master.
interface program_loader_if #(
    parameter int AB = 11
);
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          restart;
    logic [AB-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          prog_we;
    logic [AB:0]   word_count;
    logic          load_done;
    logic          mem_full;

    modport master (
        output rx_data, rx_done, restart,
        input  prog_addr, prog_data, prog_we, word_count, load_done, mem_full
    );

    modport slave (
        input  rx_data, rx_done, restart,
        output prog_addr, prog_data, prog_we, word_count, load_done, mem_full
    );
endinterface

// File: rtl/program_loader.sv
// Assembles 16-bit instruction words from a high-byte-first byte stream and
// writes them to consecutive program-memory addresses until HLT or memory end.
module program_loader #(
    parameter int AB = 11
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AB-1:0] LAST_ADDR = {AB{1'b1}};
    localparam logic [4:0]    OP_HLT    = 5'b00000;

    state_t        state;
    logic [7:0]    hi;
    logic [AB-1:0] addr;
    logic [15:0]   data;
    logic          we;
    logic [AB:0]   count;
    logic          done;
    logic          full;

    // All outputs come straight from flops.
    assign bus.prog_addr  = addr;
    assign bus.prog_data  = data;
    assign bus.prog_we    = we;
    assign bus.word_count = count;
    assign bus.load_done  = done;
    assign bus.mem_full   = full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_HI;
            hi    <= 8'h00;
            addr  <= '0;
            data  <= 16'h0000;
            we    <= 1'b0;
            count <= '0;
            done  <= 1'b0;
            full  <= 1'b0;
        end else if (bus.restart) begin
            // prog_data is deliberately kept: it only ever reflects the last write.
            state <= WAIT_HI;
            hi    <= 8'h00;
            addr  <= '0;
            we    <= 1'b0;
            count <= '0;
            done  <= 1'b0;
            full  <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                WAIT_HI: begin
                    if (bus.rx_done) begin
                        hi    <= bus.rx_data;
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (bus.rx_done) begin
                        data  <= {hi, bus.rx_data};
                        we    <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    count <= count + 1'b1;
                    if (data[15:11] == OP_HLT) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (addr == LAST_ADDR) begin
                        // Memory exhausted: stop rather than wrap onto word 0.
                        done  <= 1'b1;
                        full  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr <= addr + 1'b1;
                        if (bus.rx_done) begin
                            hi    <= bus.rx_data;
                            state <= WAIT_LO;
                        end else begin
                            state <= WAIT_HI;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= WAIT_HI;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a full-size instance and an AB=3 instance
// for the memory-end case; writes are logged on the falling edge.
module tb_program_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_loader_if #(.AB(11)) bi ();
    program_loader_if #(.AB(3))  bs ();

    program_loader #(.AB(11)) dut (.clk(clk), .reset(reset), .bus(bi));
    program_loader #(.AB(3))  dut_s (.clk(clk), .reset(reset), .bus(bs));

    int checks = 0;
    int failures = 0;

    int          oa[$];
    logic [15:0] od[$];
    int          sa[$];
    logic [15:0] sd[$];

    always @(negedge clk) begin
        if (bi.prog_we === 1'b1) begin
            oa.push_back(int'(bi.prog_addr));
            od.push_back(bi.prog_data);
        end
        if (bs.prog_we === 1'b1) begin
            sa.push_back(int'(bs.prog_addr));
            sd.push_back(bs.prog_data);
        end
    end

    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (sel) begin bs.rx_data = b; bs.rx_done = 1'b1; end
        else     begin bi.rx_data = b; bi.rx_done = 1'b1; end
        @(negedge clk);
        bi.rx_done = 1'b0;
        bs.rx_done = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (bi.prog_addr !== 11'd0 || bi.prog_data !== 16'h0 || bi.prog_we !== 1'b0 ||
            bi.word_count !== 12'd0 || bi.load_done !== 1'b0 || bi.mem_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%0d data=%h we=%b wc=%0d done=%b full=%b, all must be 0",
                     bi.prog_addr, bi.prog_data, bi.prog_we, bi.word_count, bi.load_done, bi.mem_full);
        end
        checks++;
        if (bs.prog_addr !== 3'd0 || bs.word_count !== 4'd0 || bs.mem_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_small: addr=%0d wc=%0d full=%b, all must be 0",
                     bs.prog_addr, bs.word_count, bs.mem_full);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        int          ea[3] = '{0, 1, 2};
        logic [15:0] ed[3] = '{16'h0805, 16'h1007, 16'h0000};
        oa.delete(); od.delete();
        send_byte(0, 8'h08);
        send_byte(0, 8'h05);
        checks++;
        if (bi.prog_we !== 1'b1 || bi.prog_addr !== 11'd0 || bi.prog_data !== 16'h0805) begin
            failures++;
            $display("FAIL write_latency: we=%b addr=%0d data=%h, need we=1 addr=0 data=0805",
                     bi.prog_we, bi.prog_addr, bi.prog_data);
        end
        settle();
        checks++;
        if (bi.prog_we !== 1'b0 || bi.prog_data !== 16'h0805 || bi.prog_addr !== 11'd1) begin
            failures++;
            $display("FAIL data_hold: we=%b data=%h addr=%0d, need we=0 data=0805 addr=1",
                     bi.prog_we, bi.prog_data, bi.prog_addr);
        end
        send_byte(0, 8'h10);
        send_byte(0, 8'h07);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        settle();
        checks++;
        if (oa.size() != 3) begin
            failures++;
            $display("FAIL basic_write_count: got %0d writes, need 3", oa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (oa[i] != ea[i] || od[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL basic_write%0d: got (%0d,%h), need (%0d,%h)", i, oa[i], od[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (bi.load_done !== 1'b1 || bi.word_count !== 12'd3 || bi.mem_full !== 1'b0 || bi.prog_addr !== 11'd2) begin
            failures++;
            $display("FAIL basic_final: done=%b wc=%0d full=%b addr=%0d, need done=1 wc=3 full=0 addr=2",
                     bi.load_done, bi.word_count, bi.mem_full, bi.prog_addr);
        end
    endtask

    task automatic test_done_ignore();
        oa.delete(); od.delete();
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        settle();
        checks++;
        if (oa.size() != 0 || bi.load_done !== 1'b1 || bi.word_count !== 12'd3 ||
            bi.prog_addr !== 11'd2 || bi.prog_data !== 16'h0000) begin
            failures++;
            $display("FAIL done_ignore: writes=%0d done=%b wc=%0d addr=%0d data=%h, need 0/1/3/2/0000",
                     oa.size(), bi.load_done, bi.word_count, bi.prog_addr, bi.prog_data);
        end
    endtask

    task automatic test_restart_collision();
        oa.delete(); od.delete();
        @(negedge clk); bi.restart = 1'b1;
        @(negedge clk); bi.restart = 1'b0;
        send_byte(0, 8'h20);
        @(negedge clk);
        bi.rx_data = 8'h21; bi.rx_done = 1'b1; bi.restart = 1'b1;
        @(negedge clk);
        bi.rx_done = 1'b0; bi.restart = 1'b0;
        #1;
        checks++;
        if (oa.size() != 0 || bi.prog_we !== 1'b0 || bi.prog_addr !== 11'd0 ||
            bi.word_count !== 12'd0 || bi.load_done !== 1'b0) begin
            failures++;
            $display("FAIL restart_collision: writes=%0d we=%b addr=%0d wc=%0d done=%b, need 0/0/0/0/0",
                     oa.size(), bi.prog_we, bi.prog_addr, bi.word_count, bi.load_done);
        end
        // Must now be in WAIT_HI: 0x0A is taken as the high byte.
        send_byte(0, 8'h0A);
        send_byte(0, 8'h0B);
        settle();
        checks++;
        if (oa.size() != 1 || oa[0] != 0 || od[0] !== 16'h0A0B) begin
            failures++;
            $display("FAIL restart_next_word: writes=%0d first=(%0d,%h), need 1 write (0,0a0b)",
                     oa.size(), (oa.size() > 0) ? oa[0] : -1, (od.size() > 0) ? od[0] : 16'hxxxx);
        end
    endtask

    task automatic test_back_to_back();
        oa.delete(); od.delete();
        @(negedge clk); bi.rx_data = 8'h0C; bi.rx_done = 1'b1;
        @(negedge clk); bi.rx_data = 8'h0D;
        @(negedge clk); bi.rx_data = 8'h0E;
        @(negedge clk); bi.rx_data = 8'h0F;
        @(negedge clk); bi.rx_done = 1'b0;
        settle();
        checks++;
        if (oa.size() != 2) begin
            failures++;
            $display("FAIL b2b_write_count: got %0d writes, need 2", oa.size());
        end else begin
            checks++;
            if (oa[0] != 1 || od[0] !== 16'h0C0D || oa[1] != 2 || od[1] !== 16'h0E0F) begin
                failures++;
                $display("FAIL b2b_writes: got (%0d,%h) (%0d,%h), need (1,0c0d) (2,0e0f)",
                         oa[0], od[0], oa[1], od[1]);
            end
        end
        checks++;
        if (bi.word_count !== 12'd3 || bi.prog_addr !== 11'd3 || bi.load_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_state: wc=%0d addr=%0d done=%b, need wc=3 addr=3 done=0",
                     bi.word_count, bi.prog_addr, bi.load_done);
        end
    endtask

    task automatic test_reset_midword();
        oa.delete(); od.delete();
        send_byte(0, 8'h12);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bi.prog_addr !== 11'd0 || bi.word_count !== 12'd0 || bi.prog_data !== 16'h0 || bi.prog_we !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: addr=%0d wc=%0d data=%h we=%b, need all 0",
                     bi.prog_addr, bi.word_count, bi.prog_data, bi.prog_we);
        end
        @(negedge clk);
        reset = 1'b1;
        send_byte(0, 8'h34);
        send_byte(0, 8'h56);
        settle();
        checks++;
        if (oa.size() != 1 || oa[0] != 0 || od[0] !== 16'h3456) begin
            failures++;
            $display("FAIL reset_midword: writes=%0d first=(%0d,%h), need 1 write (0,3456)",
                     oa.size(), (oa.size() > 0) ? oa[0] : -1, (od.size() > 0) ? od[0] : 16'hxxxx);
        end
    endtask

    task automatic test_mem_full();
        sa.delete(); sd.delete();
        for (int i = 0; i < 8; i++) begin
            send_byte(1, 8'h08);
            send_byte(1, 8'(i));
        end
        settle();
        checks++;
        if (sa.size() != 8) begin
            failures++;
            $display("FAIL full_write_count: got %0d writes, need 8", sa.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (sa[i] != i || sd[i] !== {8'h08, 8'(i)}) begin
                    failures++;
                    $display("FAIL full_write%0d: got (%0d,%h), need (%0d,%h)", i, sa[i], sd[i], i, {8'h08, 8'(i)});
                end
            end
        end
        checks++;
        if (bs.mem_full !== 1'b1 || bs.load_done !== 1'b1 || bs.prog_addr !== 3'd7 || bs.word_count !== 4'd8) begin
            failures++;
            $display("FAIL full_final: full=%b done=%b addr=%0d wc=%0d, need 1/1/7/8",
                     bs.mem_full, bs.load_done, bs.prog_addr, bs.word_count);
        end
        sa.delete(); sd.delete();
        send_byte(1, 8'h09);
        send_byte(1, 8'h09);
        settle();
        checks++;
        if (sa.size() != 0 || bs.prog_addr !== 3'd7) begin
            failures++;
            $display("FAIL full_no_wrap: writes=%0d addr=%0d, need 0 writes addr=7", sa.size(), bs.prog_addr);
        end
        @(negedge clk); bs.restart = 1'b1;
        @(negedge clk); bs.restart = 1'b0;
        #1;
        checks++;
        if (bs.mem_full !== 1'b0 || bs.load_done !== 1'b0 || bs.prog_addr !== 3'd0 || bs.word_count !== 4'd0) begin
            failures++;
            $display("FAIL full_restart: full=%b done=%b addr=%0d wc=%0d, need all 0",
                     bs.mem_full, bs.load_done, bs.prog_addr, bs.word_count);
        end
    endtask

    initial begin
        bi.rx_data = 8'h00; bi.rx_done = 1'b0; bi.restart = 1'b0;
        bs.rx_data = 8'h00; bs.rx_done = 1'b0; bs.restart = 1'b0;
        reset = 1'b1;
        test_reset();
        test_basic_load();
        test_done_ignore();
        test_restart_collision();
        test_back_to_back();
        test_reset_midword();
        test_mem_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one parameter: AB, default 11, the program-memory address width, equal to the control block's Addr width.
REQ-002 Port clk, input, 1 bit: sole clock, rising-edge active.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port rx_data, input, 8 bits: received byte, valid only while rx_done=1.
REQ-005 Port rx_done, input, 1 bit: one-cycle strobe, one received byte.
REQ-006 Port restart, input, 1 bit: synchronous request to start a new load.
REQ-007 Port prog_addr, output, AB bits: program-memory write address.
REQ-008 Port prog_data, output, 16 bits: instruction word, {OpCode[4:0], operand[10:0]}.
REQ-009 Port prog_we, output, 1 bit: program-memory write strobe.
REQ-010 Port word_count, output, AB+1 bits: number of words written in the current load.
REQ-011 Port load_done, output, 1 bit: load finished; drives CPU run enable.
REQ-012 Port mem_full, output, 1 bit: load ended because the last address was written.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 FSM states SHALL be WAIT_HI, WAIT_LO, WRITE and DONE.
REQ-015 In WAIT_HI, rx_done=1 SHALL latch rx_data as the high byte and move to WAIT_LO.
REQ-016 In WAIT_LO, rx_done=1 SHALL latch rx_data as the low byte and move to WRITE.
REQ-017 Byte order SHALL be high byte first, then low byte.
REQ-018 In WRITE, prog_we SHALL be 1 for exactly one cycle, with prog_addr = current address and prog_data = {hi, lo}.
REQ-019 Latency SHALL be 1 cycle from the low-byte rx_done to prog_we=1.
REQ-020 On leaving WRITE, word_count SHALL increment by 1.
REQ-021 Leaving WRITE when prog_data[15:11] = 5'b00000 (HLT) SHALL go to DONE and leave prog_addr unchanged.
REQ-022 Leaving WRITE when prog_addr = 2^AB-1 and the word is not HLT SHALL go to DONE, set mem_full=1 and leave prog_addr unchanged (no wrap).
REQ-023 Leaving WRITE in all other cases SHALL increment prog_addr by 1 and go to WAIT_HI.
REQ-024 rx_done in WRITE SHALL be captured as the next high byte (go to WAIT_LO) unless the transition is to DONE, in which case it is discarded.
REQ-025 load_done SHALL be 1 exactly while in DONE.
REQ-026 In DONE, rx_done SHALL be ignored.
REQ-027 restart=1 in any state SHALL take priority over rx_done and go to WAIT_HI with prog_addr=0, word_count=0, mem_full=0, prog_we=0 and any latched bytes discarded.
REQ-028 prog_data SHALL hold its last written value outside WRITE.
REQ-029 prog_we SHALL never be 1 in WAIT_HI, WAIT_LO or DONE.

Reset
REQ-030 reset=0 SHALL immediately force: state WAIT_HI, prog_addr=0, prog_data=0, prog_we=0, word_count=0, load_done=0, mem_full=0, latched bytes=0.
REQ-031 Reset asserted mid-word (WAIT_LO or WRITE) SHALL abort the word with no write after release.
REQ-032 The first edge after reset release SHALL be ordinary WAIT_HI operation.

Verification
REQ-033 Bytes 0x08,0x05,0x10,0x07,0x00,0x00 -> writes (0,0x0805), (1,0x1007), (2,0x0000); load_done=1; word_count=3; mem_full=0.
REQ-034 AB=3, eight non-HLT words -> writes at addresses 0..7; mem_full=1, load_done=1, prog_addr=7, word_count=8.
REQ-035 High byte 0x12 sent, then reset pulse, then 0x34,0x56 -> single write of 0x3456 at address 0.
REQ-036 restart in the same cycle as a low-byte rx_done -> no write; state WAIT_HI; prog_addr=0.
REQ-037 Bytes sent while load_done=1 -> no prog_we; outputs unchanged.
REQ-038 rx_done in the WRITE cycle of a non-HLT word -> that byte becomes the next high byte, and the following word is written correctly at the next address.
